csr_unit: RTL

- Machine-mode CSR file and trap responder for the single-cycle RV32I core.
- Services the decoder's CSR requests: csr_reg_rd / csr_reg_wr, with the address taken from inst[31:20], and MRET.
- Accepts timer and external interrupt lines, then redirects fetch by asserting epc_taken with a target PC on epc.
- Holds the mcycle counter.

---
 rtl/csr_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/csr_unit.sv
// csr_unit
// Machine-mode CSR file and trap responder for the single-cycle RV32I core.
// Serves CSR reads/writes from the decoder, responds to MRET, takes timer
// and external interrupts, and keeps the 64-bit mcycle counter.
//
// Ports:
//   clk        core clock
//   rst        synchronous active-high reset
//   inst       current instruction; CSR address is inst[31:20]
//   pc         PC of the current instruction
//   wdata      CSR write data (rs1 value)
//   csr_reg_rd CSR read request
//   csr_reg_wr CSR write request
//   is_mret    current instruction is MRET
//   timer_intr level machine timer interrupt
//   ext_intr   level machine external interrupt
//   rdata      CSR read data (old value on a read-modify-write)
//   epc        redirect target PC
//   epc_taken  redirect fetch to epc this cycle
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          MCYCLE_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] wdata,
  input  logic        csr_reg_rd,
  input  logic        csr_reg_wr,
  input  logic        is_mret,
  input  logic        timer_intr,
  input  logic        ext_intr,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        epc_taken
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  logic [11:0] csr_addr;
  logic [19:0] unused_inst_bits;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_mtie;
  logic        mie_meie;
  logic        mip_mtip;
  logic        mip_meip;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [63:0] mcycle;

  logic        irq_ext;
  logic        irq_timer;
  logic        take;
  logic        mret_fire;
  logic        wr_en;
  logic [31:0] trap_cause;
  logic [31:0] trap_base;
  logic [31:0] trap_target;

  assign csr_addr         = inst[31:20];
  assign unused_inst_bits = inst[19:0];

  // Interrupt selection: external beats timer, and nothing is taken in reset.
  assign irq_ext    = mip_meip & mie_meie;
  assign irq_timer  = mip_mtip & mie_mtie;
  assign take       = ~rst & mstatus_mie & (irq_ext | irq_timer);
  assign trap_cause = irq_ext ? CAUSE_EXT : CAUSE_TIMER;
  assign mret_fire  = ~rst & is_mret & ~take;

  // A trap or MRET in the same cycle swallows any CSR write, so the
  // interrupted instruction can simply re-execute after the return.
  assign wr_en = csr_reg_wr & ~take & ~is_mret;

  // Vectored mode only for mode==1; modes 2/3 fall back to direct.
  // 4*cause[30:0] truncated to 32 bits is just cause[29:0] shifted by 2.
  assign trap_base   = {mtvec[31:2], 2'b00};
  assign trap_target = (mtvec[1:0] == 2'b01) ? trap_base + {trap_cause[29:0], 2'b00}
                                             : trap_base;

  // Read mux returns the pre-edge value, which gives CSRRW its old-value
  // semantics when read and write land in the same cycle.
  always_comb begin
    rdata = 32'h0;
    if (!rst && csr_reg_rd) begin
      case (csr_addr)
        ADDR_MSTATUS: rdata = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
        ADDR_MIE:     rdata = {20'h0, mie_meie, 3'b000, mie_mtie, 7'h00};
        ADDR_MTVEC:   rdata = mtvec;
        ADDR_MEPC:    rdata = mepc;
        ADDR_MCAUSE:  rdata = mcause;
        ADDR_MIP:     rdata = {20'h0, mip_meip, 3'b000, mip_mtip, 7'h00};
        ADDR_MCYCLE:  rdata = mcycle[31:0];
        ADDR_MCYCLEH: rdata = mcycle[63:32];
        default:      rdata = 32'h0;
      endcase
    end
  end

  // Fetch redirect: trap entry has priority over MRET.
  always_comb begin
    epc_taken = 1'b0;
    epc       = 32'h0;
    if (take) begin
      epc_taken = 1'b1;
      epc       = trap_target;
    end else if (mret_fire) begin
      epc_taken = 1'b1;
      epc       = mepc;
    end
  end

  // Architectural state. mip is resampled every cycle, giving the one-cycle
  // interrupt latency. mcycle keeps counting through traps and MRET; a write
  // to either half replaces it and skips that cycle's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mip_mtip     <= 1'b0;
      mip_meip     <= 1'b0;
      mtvec        <= MTVEC_RESET;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
      mcycle       <= 64'h0;
    end else begin
      mip_mtip <= timer_intr;
      mip_meip <= ext_intr;

      if (!MCYCLE_EN) begin
        mcycle <= 64'h0;
      end else if (wr_en && csr_addr == ADDR_MCYCLE) begin
        mcycle[31:0] <= wdata;
      end else if (wr_en && csr_addr == ADDR_MCYCLEH) begin
        mcycle[63:32] <= wdata;
      end else begin
        mcycle <= mcycle + 64'd1;
      end

      if (take) begin
        mepc         <= pc;
        mcause       <= trap_cause;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_fire) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (wr_en) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie  <= wdata[3];
            mstatus_mpie <= wdata[7];
          end
          ADDR_MIE: begin
            mie_mtie <= wdata[7];
            mie_meie <= wdata[11];
          end
          ADDR_MTVEC:  mtvec  <= wdata;
          ADDR_MEPC:   mepc   <= {wdata[31:2], 2'b00};
          ADDR_MCAUSE: mcause <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule
